// File: rtl/craft_pkg.sv
// Shared constants and types for the CRAFT round controller.
package craft_pkg;

  localparam int unsigned NROUNDS = 32;

  localparam logic [3:0] RC_A_SEED = 4'h1;
  localparam logic [2:0] RC_B_SEED = 3'h1;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } craft_state_e;

endpackage

// File: rtl/craft_rc_lfsr.sv
// CRAFT round-constant generator: a 4-bit and a 3-bit LFSR stepped together.
module craft_rc_lfsr
  import craft_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  output logic [7:0] rc
);

  logic [3:0] a_q, a_d;
  logic [2:0] b_q, b_d;

  // clr wins over en so the final round leaves both LFSRs at seed
  always_comb begin
    a_d = a_q;
    b_d = b_q;
    if (clr) begin
      a_d = RC_A_SEED;
      b_d = RC_B_SEED;
    end else if (en) begin
      a_d = {a_q[0] ^ a_q[1], a_q[3:1]};
      b_d = {b_q[0] ^ b_q[1], b_q[2:1]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q <= RC_A_SEED;
      b_q <= RC_B_SEED;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
    end
  end

  assign rc = {a_q, 1'b0, b_q};

endmodule

// File: rtl/craft_round_ctrl.sv
// CRAFT iterative-datapath sequencer: block handshake, 32-round loop, round
// index, round constant, tweakey select and datapath enables.
module craft_round_ctrl
  import craft_pkg::*;
#(
  parameter int unsigned NROUNDS = craft_pkg::NROUNDS,
  parameter int unsigned RC_W    = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            pause,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            ld,
  output logic            rnd_en,
  output logic            last_round,
  output logic [4:0]      round_idx,
  output logic [1:0]      tk_sel,
  output logic [RC_W-1:0] rc
);

  localparam logic [4:0] LastIdx = 5'(NROUNDS - 1);

  craft_state_e state_q, state_d;
  logic [4:0]   round_q, round_d;
  logic         lfsr_clr, lfsr_en;
  logic [7:0]   rc_raw;

  always_comb begin
    state_d    = state_q;
    round_d    = round_q;
    in_ready   = 1'b0;
    ld         = 1'b0;
    rnd_en     = 1'b0;
    last_round = 1'b0;
    lfsr_clr   = 1'b0;
    lfsr_en    = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          ld       = 1'b1;
          state_d  = StRun;
          round_d  = '0;
          lfsr_clr = 1'b1;
        end
      end
      StRun: begin
        if (!pause) begin
          rnd_en = 1'b1;
          if (round_q == LastIdx) begin
            last_round = 1'b1;
            state_d    = StDone;
            round_d    = '0;
            lfsr_clr   = 1'b1;
          end else begin
            round_d = round_q + 5'd1;
            lfsr_en = 1'b1;
          end
        end
      end
      StDone: begin
        // Taking the result and a new block in one cycle avoids a bubble
        in_ready = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            ld       = 1'b1;
            state_d  = StRun;
            round_d  = '0;
            lfsr_clr = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      round_q <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
    end
  end

  craft_rc_lfsr u_rc_lfsr (
    .clk (clk),
    .rst (rst),
    .clr (lfsr_clr),
    .en  (lfsr_en),
    .rc  (rc_raw)
  );

  assign out_valid = (state_q == StDone);
  assign round_idx = round_q;
  assign tk_sel    = round_q[1:0];
  assign rc        = rc_raw;

endmodule

// File: tb/tb_craft_round_ctrl.sv
// Self-checking bench for craft_round_ctrl: directed scenarios plus random
// handshake/pause traffic checked against a transaction-level model.
module tb_craft_round_ctrl;

  localparam int NR     = 32;
  localparam int PhIdle = 0;
  localparam int PhRun  = 1;
  localparam int PhDone = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, pause, out_ready;
  logic       in_ready, out_valid, ld, rnd_en, last_round;
  logic [4:0] round_idx;
  logic [1:0] tk_sel;
  logic [7:0] rc;

  craft_round_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .pause      (pause),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ld         (ld),
    .rnd_en     (rnd_en),
    .last_round (last_round),
    .round_idx  (round_idx),
    .tk_sel     (tk_sel),
    .rc         (rc)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int   m_phase, m_round, m_done_cnt;
  int   acc_cyc, pause_cnt, blocks_done;
  logic prev_ov;
  logic [7:0] rc_tab [NR];
  // Published constants: rounds 0..5, then rounds 30 and 31
  logic [7:0] rc_lit [8] = '{8'h11, 8'h84, 8'h42, 8'h25, 8'h96, 8'hC7, 8'h12, 8'h85};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic build_rc_tab();
    logic [3:0] a;
    logic [2:0] b;
    a = 4'h1;
    b = 3'h1;
    for (int i = 0; i < NR; i++) begin
      rc_tab[i] = {a, 1'b0, b};
      a = {a[0] ^ a[1], a[3:1]};
      b = {b[0] ^ b[1], b[2:1]};
    end
  endtask

  task automatic check_outputs();
    logic e_ir, e_ld, e_rnd, e_last, e_ov;
    e_ir   = (m_phase == PhIdle) || (m_phase == PhDone && out_ready);
    e_ld   = e_ir && in_valid;
    e_rnd  = (m_phase == PhRun) && !pause;
    e_last = e_rnd && (m_round == NR - 1);
    e_ov   = (m_phase == PhDone);
    chk("in_ready",   32'(in_ready),   32'(e_ir));
    chk("ld",         32'(ld),         32'(e_ld));
    chk("rnd_en",     32'(rnd_en),     32'(e_rnd));
    chk("last_round", 32'(last_round), 32'(e_last));
    chk("out_valid",  32'(out_valid),  32'(e_ov));
    chk("round_idx",  32'(round_idx),  32'(m_round));
    chk("tk_sel",     32'(tk_sel),     32'(m_round % 4));
    chk("rc",         32'(rc),         32'(rc_tab[m_round]));
    if (m_phase == PhRun) begin
      if (m_round < 6) chk("rc_const", 32'(rc), 32'(rc_lit[m_round]));
      else if (m_round >= 30) chk("rc_const", 32'(rc), 32'(rc_lit[m_round - 24]));
    end
  endtask

  task automatic model_step(input logic iv, input logic pz, input logic ordy);
    logic acc;
    acc = iv && ((m_phase == PhIdle) || (m_phase == PhDone && ordy));
    if (acc) begin
      m_phase   = PhRun;
      m_round   = 0;
      acc_cyc   = cyc;
      pause_cnt = 0;
    end else if (m_phase == PhRun) begin
      if (pz) pause_cnt++;
      else if (m_round == NR - 1) begin
        m_phase = PhDone;
        m_round = 0;
        m_done_cnt++;
      end else m_round++;
    end else if (m_phase == PhDone && ordy) begin
      m_phase = PhIdle;
    end
  endtask

  task automatic cycle(input logic iv, input logic pz, input logic ordy);
    in_valid  = iv;
    pause     = pz;
    out_ready = ordy;
    @(negedge clk);
    check_outputs();
    if (out_valid && !prev_ov) begin
      chk("latency", 32'(cyc - acc_cyc), 32'(NR + 1 + pause_cnt));
      blocks_done++;
    end
    prev_ov = out_valid;
    model_step(iv, pz, ordy);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    pause     = 1'b0;
    out_ready = 1'b0;
    rst       = 1'b0;
    #1;
    m_phase = PhIdle;
    m_round = 0;
    prev_ov = 1'b0;
    check_outputs();
    chk("reset_rc", 32'(rc), 32'h11);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    build_rc_tab();
    m_done_cnt  = 0;
    blocks_done = 0;
    acc_cyc     = 0;
    pause_cnt   = 0;
    rst       = 1'b0;
    in_valid  = 1'b0;
    pause     = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Single block, then 10 cycles of backpressure, then release to idle
    cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < NR; i++) cycle(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0);

    // Pause for 3 cycles at round 5
    cycle(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 40 && m_phase != PhDone; i++) cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);

    // Pause while at round 31
    cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < NR - 1; i++) cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b1);

    // Back-to-back blocks
    for (int i = 0; i < 3 * (NR + 1) + 2; i++) cycle(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 40 && m_phase != PhIdle; i++) cycle(1'b0, 1'b0, 1'b1);

    // Reset at round 17, then a full clean block
    cycle(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 17; i++) cycle(1'b0, 1'b0, 1'b1);
    do_reset();
    cycle(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 40 && m_phase != PhIdle; i++) cycle(1'b0, 1'b0, 1'b1);

    // Random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 699) == 0) do_reset();
      else cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0),
                 1'($urandom_range(0, 1)));
    end

    chk("blocks_completed", 32'(blocks_done), 32'(m_done_cnt));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
